// File: rtl/ws2812_bit_serializer.sv
// Pulls 24-bit RGB words from the frame controller and drives them MSB-first onto the
// WS2812 one-wire line as pulse-width bits, closing each frame with a low latch period.
module ws2812_bit_serializer #(
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int RESET_CYC = 2600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_ready,
    input  logic        data_valid,
    input  logic [23:0] rgb,
    output logic        tx_done,
    output logic        busy,
    output logic        frame_done,
    output logic        dout
);

    localparam int CYC_W = $clog2(BIT_CYC);
    localparam int LAT_W = $clog2(RESET_CYC);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_T0H  = CYC_W'(T0H_CYC);
    localparam logic [CYC_W-1:0] CYC_T1H  = CYC_W'(T1H_CYC);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYC - 1);
    localparam logic [4:0]       BIT_LAST = 5'd23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         bit_q, bit_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [23:0]        shift_q, shift_d;
    logic               cur_last_q, cur_last_d;
    logic [23:0]        nxt_rgb_q, nxt_rgb_d;
    logic               nxt_last_q, nxt_last_d;
    logic               nxt_vld_q, nxt_vld_d;
    logic               aborted_q, aborted_d;
    logic               dout_q, dout_d;
    logic               tx_done_q, tx_done_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    always_comb begin
        // NOTE: every _d starts from a default so no path through the case infers a latch.
        state_d    = state_q;
        bit_d      = bit_q;
        cyc_d      = cyc_q;
        lat_d      = lat_q;
        shift_d    = shift_q;
        cur_last_d = cur_last_q;
        nxt_rgb_d  = nxt_rgb_q;
        nxt_last_d = nxt_last_q;
        nxt_vld_d  = nxt_vld_q;
        aborted_d  = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (data_ready) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d    = S_SEND;
                shift_d    = rgb;
                cur_last_d = data_valid;
                bit_d      = '0;
                cyc_d      = '0;
                nxt_vld_d  = 1'b0;
            end
            S_SEND: begin
                // The prefetch request went out in cycle 0 of this word; the reply lands now.
                if (bit_q == '0 && cyc_q == CYC_ONE && !cur_last_q && !nxt_vld_q) begin
                    nxt_rgb_d  = rgb;
                    nxt_last_d = data_valid;
                    nxt_vld_d  = 1'b1;
                end
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (cur_last_q || !nxt_vld_q) begin
                            state_d   = S_LATCH;
                            lat_d     = '0;
                            aborted_d = !cur_last_q;
                        end else begin
                            shift_d    = nxt_rgb_q;
                            cur_last_d = nxt_last_q;
                            nxt_vld_d  = 1'b0;
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d = data_ready ? S_REQ : S_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing the frame enable mid-frame overrides whatever the case above decided.
        if (!data_ready && (state_q == S_REQ || state_q == S_WAIT || state_q == S_SEND)) begin
            state_d   = S_LATCH;
            lat_d     = '0;
            aborted_d = 1'b1;
            nxt_vld_d = 1'b0;
        end

        // Outputs are decoded from the next state so they line up with it once registered.
        tx_done_d    = (state_d == S_REQ) ||
                       (state_d == S_SEND && bit_d == '0 && cyc_d == '0 && !cur_last_d);
        dout_d       = (state_d == S_SEND) && (cyc_d < (shift_d[23] ? CYC_T1H : CYC_T0H));
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_LATCH) && (lat_d == LAT_LAST) && !aborted_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_q        <= '0;
            cyc_q        <= '0;
            lat_q        <= '0;
            shift_q      <= '0;
            cur_last_q   <= 1'b0;
            nxt_rgb_q    <= '0;
            nxt_last_q   <= 1'b0;
            nxt_vld_q    <= 1'b0;
            aborted_q    <= 1'b0;
            dout_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            cyc_q        <= cyc_d;
            lat_q        <= lat_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            nxt_rgb_q    <= nxt_rgb_d;
            nxt_last_q   <= nxt_last_d;
            nxt_vld_q    <= nxt_vld_d;
            aborted_q    <= aborted_d;
            dout_q       <= dout_d;
            tx_done_q    <= tx_done_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign tx_done    = tx_done_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_bit_serializer.sv
// Directed bench for ws2812_bit_serializer: a controller model answers tx_done, queues the
// expected bits, and a line monitor checks every pulse width, bit period and latch length.
module tb_ws2812_bit_serializer;

    localparam int T0H = 20;
    localparam int T1H = 40;
    localparam int BIT = 63;
    localparam int RST = 2600;

    typedef struct packed {
        logic val;
        logic last;
    } exp_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ready = 1'b0;
    logic        data_valid = 1'b0;
    logic [23:0] rgb = '0;
    logic        tx_done;
    logic        busy;
    logic        frame_done;
    logic        dout;

    int total = 0;
    int bad   = 0;

    word_t word_q[$];
    exp_t  exp_q[$];
    int    tx_cnt = 0;
    int    pulse_cnt = 0;
    int    rise_cnt = 0;
    int    fd_cnt = 0;
    logic  mon_en = 1'b0;

    ws2812_bit_serializer #(
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .BIT_CYC  (BIT),
        .RESET_CYC(RST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_ready(data_ready),
        .data_valid(data_valid),
        .rgb       (rgb),
        .tx_done   (tx_done),
        .busy      (busy),
        .frame_done(frame_done),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Controller model: answer each request one edge later and queue the bits it implies.
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            word_t w;
            tx_cnt++;
            @(posedge clk);
            #1;
            if (word_q.size() == 0) begin
                check("tx_done_without_word", 0, 1);
            end else begin
                w          = word_q.pop_front();
                rgb        = w.rgb;
                data_valid = w.last;
                for (int i = 23; i >= 0; i--) exp_q.push_back('{w.rgb[i], w.last && (i == 0)});
            end
        end
    end

    // Line monitor: everything is sampled on the falling edge, away from the DUT's edge.
    logic prev_dout = 1'b0;
    logic have_prev = 1'b0;
    logic prev_last = 1'b0;
    int   hi_cnt = 0;
    int   since_rise = 0;

    always @(negedge clk) begin
        logic rise, fall;
        exp_t e;
        rise = (dout === 1'b1) && !prev_dout;
        fall = (dout !== 1'b1) && prev_dout;
        if (rise) rise_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (!mon_en) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            if (rise) begin
                if (have_prev && !prev_last) check("bit_period", since_rise + 1, BIT);
                else if (have_prev) check("frame_gap_min", 32'(since_rise + 1 >= BIT + RST + 2), 1);
                hi_cnt = 1;
                pulse_cnt++;
            end else if (dout === 1'b1) begin
                hi_cnt++;
            end
            if (fall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check(e.val ? "width_one" : "width_zero", hi_cnt, e.val ? T1H : T0H);
                    prev_last = e.last;
                    have_prev = 1'b1;
                end
            end
            if (frame_done === 1'b1) begin
                check("latch_len_to_frame_done", since_rise + 1, BIT + RST - 1);
                check("bits_left_at_frame_done", exp_q.size(), 0);
            end
        end
        since_rise = rise ? 0 : since_rise + 1;
        prev_dout  = (dout === 1'b1);
    end

    task automatic wait_fd(input int budget);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("frame_done_timeout", 0, 1);
        #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tx0, p0, f0, target, n, seen_tx, seen_fd, seen_hi;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        mon_en = 1'b1;

        // Single-word frame
        word_q.push_back('{24'hFF00FF, 1'b1});
        tx0 = tx_cnt; p0 = pulse_cnt; f0 = fd_cnt;
        data_ready = 1'b1;
        wait_fd(20000);
        check("t1_busy_at_frame_done", busy, 1);
        data_ready = 1'b0;
        @(negedge clk);
        check("t1_busy_after_latch", busy, 0);
        check("t1_tx_pulses", tx_cnt - tx0, 1);
        check("t1_bits", pulse_cnt - p0, 24);
        check("t1_frame_done", fd_cnt - f0, 1);

        // Five-word frame, gap-free
        word_q.push_back('{24'hFF00FF, 1'b0});
        word_q.push_back('{24'h00FF00, 1'b0});
        word_q.push_back('{24'hAA55AA, 1'b0});
        word_q.push_back('{24'hA543D5, 1'b0});
        word_q.push_back('{24'hA543D5, 1'b1});
        tx0 = tx_cnt; p0 = pulse_cnt; f0 = fd_cnt;
        data_ready = 1'b1;
        wait_fd(30000);
        data_ready = 1'b0;
        @(negedge clk);
        check("t2_tx_pulses", tx_cnt - tx0, 5);
        check("t2_bits", pulse_cnt - p0, 120);
        check("t2_frame_done", fd_cnt - f0, 1);

        // All-zero and all-one words
        word_q.push_back('{24'h000000, 1'b0});
        word_q.push_back('{24'hFFFFFF, 1'b1});
        tx0 = tx_cnt; p0 = pulse_cnt;
        data_ready = 1'b1;
        wait_fd(20000);
        data_ready = 1'b0;
        @(negedge clk);
        check("t6_tx_pulses", tx_cnt - tx0, 2);
        check("t6_bits", pulse_cnt - p0, 48);

        // Back-to-back frames with data_ready held high
        word_q.push_back('{24'h123456, 1'b1});
        word_q.push_back('{24'h0F0F0F, 1'b0});
        word_q.push_back('{24'hC0FFEE, 1'b1});
        tx0 = tx_cnt; f0 = fd_cnt;
        data_ready = 1'b1;
        wait_fd(20000);
        check("t3_busy_at_fd1", busy, 1);
        @(negedge clk);
        check("t3_req_after_latch", tx_done, 1);
        check("t3_no_fd_overlap", frame_done, 0);
        check("t3_busy_in_req", busy, 1);
        wait_fd(20000);
        data_ready = 1'b0;
        @(negedge clk);
        check("t3_idle_busy", busy, 0);
        check("t3_tx_pulses", tx_cnt - tx0, 3);
        check("t3_frame_done", fd_cnt - f0, 2);

        // Abort during bit 10 of word 2
        word_q.push_back('{24'h5A5A5A, 1'b0});
        word_q.push_back('{24'hC3C3C3, 1'b0});
        word_q.push_back('{24'h0F0F0F, 1'b1});
        target = rise_cnt + 35;
        f0 = fd_cnt;
        data_ready = 1'b1;
        n = 0;
        while (rise_cnt < target && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 5000) check("t4_rise_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("t4_dout_high_before_drop", dout, 1);
        tx0 = tx_cnt;
        mon_en = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);
        check("t4_dout_low_next_cycle", dout, 0);
        n = 0; seen_tx = 0; seen_fd = 0; seen_hi = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            if (tx_done === 1'b1) seen_tx++;
            if (frame_done === 1'b1) seen_fd++;
            if (dout === 1'b1) seen_hi++;
            @(negedge clk);
        end
        check("t4_latch_cycles", n, RST);
        check("t4_no_tx_done", seen_tx, 0);
        check("t4_no_frame_done", seen_fd, 0);
        check("t4_dout_low_in_latch", seen_hi, 0);
        repeat (10) @(negedge clk);
        check("t4_idle_busy", busy, 0);
        check("t4_tx_total", tx_cnt - tx0, 0);
        check("t4_fd_total", fd_cnt - f0, 0);
        word_q.delete();

        // Async reset during the high phase of a bit, then a clean frame afterwards
        word_q.push_back('{24'hFFFFFF, 1'b1});
        mon_en = 1'b1;
        target = rise_cnt + 4;
        data_ready = 1'b1;
        n = 0;
        while (rise_cnt < target && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("t5_rise_timeout", 0, 1);
        repeat (5) @(negedge clk);
        check("t5_dout_high_before_rst", dout, 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_dout", dout, 0);
        check("t5_rst_tx_done", tx_done, 0);
        check("t5_rst_busy", busy, 0);
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_tx = 0; seen_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1 || busy === 1'b1) seen_tx++;
            if (dout === 1'b1) seen_hi++;
        end
        check("t5_idle_after_release", seen_tx, 0);
        check("t5_dout_low_after_release", seen_hi, 0);
        word_q.delete();
        word_q.push_back('{24'h800001, 1'b1});
        tx0 = tx_cnt; p0 = pulse_cnt; f0 = fd_cnt;
        mon_en = 1'b1;
        @(negedge clk);
        data_ready = 1'b1;
        wait_fd(20000);
        data_ready = 1'b0;
        @(negedge clk);
        check("t5_tx_pulses", tx_cnt - tx0, 1);
        check("t5_bits", pulse_cnt - p0, 24);
        check("t5_frame_done", fd_cnt - f0, 1);
        check("t5_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
